// File: rtl/byte_serial_subtractor_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : byte_serial_subtractor_pkg
//  Description : Shared FSM state type and default operand size for the
//                byte-serial subtractor.
//  Revision    : 1.0 - initial release
// ============================================================================
package byte_serial_subtractor_pkg;

    // Default operand size in bytes (operand width = 8 * N_BYTES)
    localparam int N_BYTES_DEFAULT = 4;

    // Control states: waiting for operands, processing bytes, holding the result
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        DONE = 2'd2
    } state_t;

endpackage : byte_serial_subtractor_pkg
`default_nettype wire

// File: rtl/byte_serial_subtractor_adder.sv
`default_nettype none
// ============================================================================
//  Module      : eightBitAdder
//  Description : 8-bit adder with carry-in and carry-out, the per-byte slice
//                of the byte-serial subtractor.
//  Revision    : 1.0 - initial release
// ============================================================================
module eightBitAdder (
    input  logic [7:0] a,
    input  logic [7:0] b,
    input  logic       cin,
    output logic [7:0] sum,
    output logic       cout
);

    // Widen to 9 bits so the carry-out falls out of the same addition
    assign {cout, sum} = {1'b0, a} + {1'b0, b} + {8'd0, cin};

endmodule : eightBitAdder
`default_nettype wire

// File: rtl/byte_serial_subtractor.sv
`default_nettype none
// ============================================================================
//  Module      : byte_serial_subtractor
//  Description : Computes x - y one byte per clock (LSB first) as x + ~y + 1,
//                reusing a single 8-bit adder. Reports borrow, signed
//                overflow and zero with the held result.
//  Revision    : 1.0 - initial release
// ============================================================================
module byte_serial_subtractor
    import byte_serial_subtractor_pkg::*;
#(
    parameter int N_BYTES = N_BYTES_DEFAULT
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [8*N_BYTES-1:0] x,
    input  logic [8*N_BYTES-1:0] y,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [8*N_BYTES-1:0] d,
    output logic                 borrow,
    output logic                 overflow,
    output logic                 zero
);

    localparam int                W        = 8 * N_BYTES;
    localparam int                IDX_W    = (N_BYTES > 1) ? $clog2(N_BYTES) : 1;
    localparam logic [IDX_W-1:0]  LAST_IDX = IDX_W'(N_BYTES - 1);

    state_t           state;
    state_t           state_nxt;
    logic [W-1:0]     x_q;        // latched minuend
    logic [W-1:0]     yn_q;       // latched inverted subtrahend
    logic [W-1:0]     d_q;        // result, filled byte by byte
    logic             carry;      // only link between consecutive bytes
    logic [IDX_W-1:0] idx;        // byte currently being processed
    logic             accept;
    logic [7:0]       add_a;
    logic [7:0]       add_b;
    logic [7:0]       add_sum;
    logic             add_cout;

    assign in_ready  = (state == IDLE);
    assign out_valid = (state == DONE);
    assign accept    = in_valid && in_ready;

    // Operands for the shared adder are selected by the byte index
    assign add_a = x_q[idx*8 +: 8];
    assign add_b = yn_q[idx*8 +: 8];

    eightBitAdder u_adder (
        .a    (add_a),
        .b    (add_b),
        .cin  (carry),
        .sum  (add_sum),
        .cout (add_cout)
    );

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_nxt;
    end

    // Next-state logic: accept -> N_BYTES processing edges -> hold until taken
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (accept) state_nxt = BUSY;
            BUSY:    if (idx == LAST_IDX) state_nxt = DONE;
            DONE:    if (out_ready) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // Datapath: latch operands on accept, then fold in one byte per edge
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            x_q   <= '0;
            yn_q  <= '0;
            d_q   <= '0;
            carry <= 1'b0;
            idx   <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (accept) begin
                        x_q   <= x;
                        yn_q  <= ~y;
                        d_q   <= '0;
                        carry <= 1'b1;   // the +1 of the two's-complement negate
                        idx   <= '0;
                    end
                end
                BUSY: begin
                    d_q[idx*8 +: 8] <= add_sum;
                    carry           <= add_cout;
                    idx             <= idx + IDX_W'(1);
                end
                default: ;
            endcase
        end
    end

    assign d = d_q;

    // Flags only mean something once the full result is held; ~yn_q restores y's sign
    assign borrow   = out_valid && !carry;
    assign zero     = out_valid && (d_q == '0);
    assign overflow = out_valid && (x_q[W-1] != ~yn_q[W-1]) && (d_q[W-1] != x_q[W-1]);

endmodule : byte_serial_subtractor
`default_nettype wire

// File: tb/tb_byte_serial_subtractor.sv
`default_nettype none
// ============================================================================
//  Module      : tb_byte_serial_subtractor
//  Description : Directed self-checking bench for byte_serial_subtractor with
//                a scoreboard of expected results.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_byte_serial_subtractor;

    localparam int NB = 4;
    localparam int W  = 8 * NB;

    typedef struct {
        logic [W-1:0] d;
        logic         borrow;
        logic         overflow;
        logic         zero;
    } exp_t;

    logic         clk;
    logic         rst_n;
    logic         in_valid;
    logic         in_ready;
    logic [W-1:0] x;
    logic [W-1:0] y;
    logic         out_valid;
    logic         out_ready;
    logic [W-1:0] d;
    logic         borrow;
    logic         overflow;
    logic         zero;

    int   checks;
    int   errors;
    exp_t sb[$];
    bit   scramble;

    byte_serial_subtractor #(.N_BYTES(NB)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .x         (x),
        .y         (y),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .d         (d),
        .borrow    (borrow),
        .overflow  (overflow),
        .zero      (zero)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [W-1:0] obs, input logic [W-1:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Reference model using whole-word arithmetic on the full operands
    function automatic exp_t model(input logic [W-1:0] a, input logic [W-1:0] b);
        exp_t e;
        e.d        = a - b;
        e.borrow   = (a < b);
        e.overflow = (a[W-1] != b[W-1]) && (e.d[W-1] != a[W-1]);
        e.zero     = (e.d == '0);
        return e;
    endfunction

    // Offer an operand pair (called #1 after a posedge) and wait for the accept edge
    task automatic send(input logic [W-1:0] a, input logic [W-1:0] b, input bit keep_valid);
        int n;
        n = 0;
        while (!in_ready && n < 20) begin
            @(posedge clk); #1;
            n++;
        end
        if (!in_ready) begin
            chk("ready_timeout", 0, 1);
        end
        x        = a;
        y        = b;
        in_valid = 1'b1;
        sb.push_back(model(a, b));
        @(posedge clk); #1;
        if (!keep_valid) begin
            in_valid = 1'b0;
            x = $urandom;
            y = $urandom;
        end
        chk("accepted_busy", W'(in_ready), 0);
    endtask

    // Track latency, hold DONE for 'hold' cycles checking stability, compare, release
    task automatic receive(input int hold);
        exp_t e;
        logic [W-1:0] d0;
        for (int k = 1; k <= NB; k++) begin
            @(posedge clk); #1;
            if (scramble) begin x = $urandom; y = $urandom; end
            chk("latency_out_valid", W'(out_valid), W'(k == NB));
            chk("busy_in_ready", W'(in_ready), 0);
        end
        d0 = d;
        for (int h = 0; h < hold; h++) begin
            @(posedge clk); #1;
            if (scramble) begin x = $urandom; y = $urandom; end
            chk("hold_out_valid", W'(out_valid), 1);
            chk("hold_in_ready", W'(in_ready), 0);
            chk("hold_d_stable", d, d0);
        end
        if (sb.size() == 0) begin
            chk("scoreboard_empty", 0, 1);
        end else begin
            e = sb.pop_front();
            chk("d", d, e.d);
            chk("borrow", W'(borrow), W'(e.borrow));
            chk("overflow", W'(overflow), W'(e.overflow));
            chk("zero", W'(zero), W'(e.zero));
        end
        out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;
        chk("release_out_valid", W'(out_valid), 0);
        chk("release_in_ready", W'(in_ready), 1);
        chk("idle_flags", {29'd0, borrow, overflow, zero}, 0);
    endtask

    initial begin
        checks    = 0;
        errors    = 0;
        scramble  = 1'b0;
        rst_n     = 1'b0;
        in_valid  = 1'b1;     // offered during reset: must not be taken
        out_ready = 1'b0;
        x         = 32'h0000_0007;
        y         = 32'h0000_0001;

        repeat (3) @(posedge clk);
        #1;
        chk("rst_in_ready", W'(in_ready), 1);
        chk("rst_out_valid", W'(out_valid), 0);
        chk("rst_d", d, 0);
        chk("rst_flags", {29'd0, borrow, overflow, zero}, 0);
        in_valid = 1'b0;
        #2 rst_n = 1'b1;
        @(posedge clk); #1;
        chk("post_rst_idle", W'(in_ready), 1);

        // Basic small difference
        send(32'h0000_0005, 32'h0000_0003, 1'b0);
        receive(0);
        // Negative result -> borrow
        send(32'h0000_0003, 32'h0000_0005, 1'b0);
        receive(0);
        // Signed overflow
        send(32'h8000_0000, 32'h0000_0001, 1'b0);
        receive(0);
        // Borrow crossing a byte boundary
        send(32'h0000_0100, 32'h0000_0001, 1'b0);
        receive(0);
        // Equal operands, consumer stalls 3 cycles
        send(32'h1234_5678, 32'h1234_5678, 1'b0);
        receive(3);
        // Positive - negative overflow case
        send(32'h7FFF_FFFF, 32'hFFFF_FFFF, 1'b0);
        receive(1);

        // Reset in the 2nd BUSY cycle aborts the operation
        send(32'hDEAD_BEEF, 32'h0123_4567, 1'b0);
        @(posedge clk); #1;
        rst_n = 1'b0;
        #1;
        chk("abort_out_valid", W'(out_valid), 0);
        chk("abort_d", d, 0);
        chk("abort_in_ready", W'(in_ready), 1);
        chk("abort_flags", {29'd0, borrow, overflow, zero}, 0);
        void'(sb.pop_back());
        #2 rst_n = 1'b1;
        @(posedge clk); #1;
        send(32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0);
        receive(0);

        // in_valid held high with changing operands: one result per accept
        scramble = 1'b1;
        send(32'h0000_1000, 32'h0000_0001, 1'b1);
        receive(2);
        send(32'hA5A5_A5A5, 32'h5A5A_5A5A, 1'b1);
        receive(0);
        scramble = 1'b0;
        in_valid = 1'b0;
        @(posedge clk); #1;
        chk("no_extra_accept", W'(in_ready), 1);
        chk("scoreboard_drained", sb.size(), 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule : tb_byte_serial_subtractor
`default_nettype wire

// File: doc/byte_serial_subtractor.md
BYTE_SERIAL_SUBTRACTOR -- requirements
Module: byte_serial_subtractor

Interface
REQ-001 SHALL have parameter N_BYTES, default 4, giving operand width W = 8*N_BYTES bits.
REQ-002 SHALL have port clk, input, 1 bit, the single clock; all state updates on the rising edge.
REQ-003 SHALL have port rst_n, input, 1 bit, asynchronous active-low reset.
REQ-004 SHALL have port in_valid, input, 1 bit, asserted when an operand pair is offered.
REQ-005 SHALL have port in_ready, output, 1 bit, asserted when the block can accept an operand pair.
REQ-006 SHALL have port x, input, W bits, the minuend.
REQ-007 SHALL have port y, input, W bits, the subtrahend.
REQ-008 SHALL have port out_valid, output, 1 bit, asserted when the result is held.
REQ-009 SHALL have port out_ready, input, 1 bit, asserted when the consumer takes the result.
REQ-010 SHALL have port d, output, W bits, the difference x - y mod 2^W.
REQ-011 SHALL have port borrow, output, 1 bit, set when x < y unsigned.
REQ-012 SHALL have port overflow, output, 1 bit, the two's-complement signed overflow.
REQ-013 SHALL have port zero, output, 1 bit, set when d == 0.

Function
REQ-014 SHALL implement the FSM states IDLE, BUSY and DONE; in_ready = 1 only in IDLE; out_valid = 1 only in DONE.
REQ-015 IDLE: on an edge where in_valid && in_ready, SHALL latch x, latch ~y, set the carry register to 1, clear the byte index, clear d, and enter BUSY.
REQ-016 BUSY: each edge SHALL add byte[idx] of x, byte[idx] of ~y and the carry, write the sum to d byte[idx], store the carry-out, and increment idx.
REQ-017 Processing runs LSB byte first; the carry register alone links bytes, with no combinational ripple across bytes.
REQ-018 The edge that processes byte N_BYTES-1 SHALL enter DONE; out_valid SHALL rise exactly N_BYTES edges after the accepting edge (4 with the default).
REQ-019 In DONE, borrow SHALL equal ~final carry and zero SHALL equal (d == 0).
REQ-020 In DONE, overflow SHALL equal (x[W-1] != y[W-1]) && (d[W-1] != x[W-1]), using the original y.
REQ-021 DONE: d and all flags SHALL hold stable until an edge with out_ready = 1, which returns the block to IDLE.
REQ-022 No overlap: an in_valid arriving in BUSY or DONE SHALL be ignored and stay pending; acceptance is earliest on the edge after the DONE-to-IDLE edge.
REQ-023 x and y changing after acceptance SHALL NOT affect the result.
REQ-024 borrow, overflow and zero SHALL read 0 outside DONE.

Reset
REQ-025 rst_n low SHALL immediately force IDLE, idx = 0, carry = 0, d = 0, out_valid = 0, borrow = overflow = zero = 0, and in_ready = 1.
REQ-026 No handshake is taken while rst_n is low.
REQ-027 Reset in BUSY or DONE SHALL abort the operation with no partial result visible.
REQ-028 The first acceptance SHALL occur no earlier than the first rising edge after rst_n rises.

Structure
REQ-029 A shared package SHALL hold the FSM state typedef (IDLE/BUSY/DONE) and the N_BYTES default constant.
REQ-030 The per-byte add SHALL be one instance of the existing eightBitAdder, with its operands muxed by idx; no other sub-module is used.

Verification
REQ-031 Scenario: x=0x00000005, y=0x00000003 -> d=0x00000002, borrow=0, overflow=0, zero=0, with out_valid 4 edges after accept.
REQ-032 Scenario: x=0x00000003, y=0x00000005 -> d=0xFFFFFFFE, borrow=1, overflow=0.
REQ-033 Scenario: x=0x80000000, y=0x00000001 -> d=0x7FFFFFFF, overflow=1, borrow=0; x=0x00000100, y=0x00000001 -> d=0x000000FF, proving the cross-byte borrow.
REQ-034 Scenario: x=y=0x12345678 with out_ready held low 3 cycles in DONE -> d=0, zero=1, outputs stable, in_ready=0 throughout; accept on release.
REQ-035 Scenario: rst_n pulsed low in the 2nd BUSY cycle -> out_valid=0, d=0, in_ready=1 immediately; the next op x=0xFFFFFFFF, y=0xFFFFFFFF -> d=0, zero=1.
REQ-036 Scenario: in_valid held high through BUSY and DONE with new operands changing -> exactly one result per accept; the second accept occurs on the edge after the DONE handshake.
